cart_mem_arb: RTL and testbench
===============================

# cart_mem_arb

Arbiter and sequencer for the single-port cartridge memory. It accepts download bytes from the ROM-init path into a small FIFO and exerts back-pressure on the download with `DL_WAIT`. It serializes those writes and CPU cartridge reads onto one request/acknowledge memory port. It sits between the ROM-init download manager and the SDRAM or BRAM cartridge controller, and lets a slow or variable-latency memory stand in for the cartridge ROM.

## Interface
Parameters:
- `AW`, 17: address width, matching the cartridge address space.
- `DEPTH`, 2: download FIFO depth. Power of two, at least 2.

Ports:
- `CLK_SYS`, in, 1: the only clock.
- `RESET`, in, 1: synchronous, active-high reset.
- `DL_ACTIVE`, in, 1: download session in progress. Cartridge select only.
- `DL_ADDR`, in, AW: download byte address.
- `DL_DATA`, in, 8: download byte.
- `DL_VALID`, in, 1: one-cycle strobe; pushes `DL_ADDR` and `DL_DATA`.
- `DL_WAIT`, out, 1: FIFO full; the producer must not strobe `DL_VALID`.
- `DL_OVF`, out, 1: sticky flag; a push was attempted while full.
- `DL_BUSY`, out, 1: download not yet fully committed to memory.
- `CPU_RD`, in, 1: one-cycle read strobe.
- `CPU_ADDR`, in, AW: read address, sampled on `CPU_RD`.
- `CPU_DATA`, out, 8: read data; held until the next read completes.
- `CPU_WAIT`, out, 1: read pending.
- `MEM_REQ`, out, 1: memory request; held until acknowledged.
- `MEM_WE`, out, 1: 1 for write, 0 for read.
- `MEM_ADDR`, out, AW: memory address.
- `MEM_DIN`, out, 8: write data to memory.
- `MEM_DOUT`, in, 8: read data from memory; valid with `MEM_ACK`.
- `MEM_ACK`, in, 1: one-cycle completion pulse; arrives at least 1 cycle after `MEM_REQ` rises.

## Operation
- **FIFO**
  - Holds `DEPTH` entries of {addr, data} and a registered count.
  - `DL_WAIT` = (count == DEPTH).
  - A push while full is dropped and sets `DL_OVF`. `DL_OVF` clears only on `RESET` or on a `DL_ACTIVE` rising edge.
  - A push and a pop in the same cycle leave the count unchanged. This is legal when full, because the pop frees the slot.
- **State machine**
  - States are IDLE, WR and RD.
  - From IDLE, priority is:
    1. FIFO non-empty: pop the head into the `MEM_*` registers with `MEM_WE`=1, and go to WR.
    2. Otherwise, a CPU read is pending and `DL_BUSY`=0: load the latched CPU address with `MEM_WE`=0, and go to RD.
    3. Otherwise, stay in IDLE.
  - In WR, when `MEM_ACK`=1, go to IDLE.
  - In RD, when `MEM_ACK`=1, capture `MEM_DOUT` into `CPU_DATA`, clear the pending read, and go to IDLE.
- **Memory request**
  - `MEM_REQ`=1 exactly while in WR or RD.
  - `MEM_ADDR`, `MEM_DIN` and `MEM_WE` stay stable for the whole request.
- **Busy**
  - `DL_BUSY` = `DL_ACTIVE` | (count != 0) | (state == WR).
  - CPU reads never interleave with a download. A read issued during a download waits until the last write has been acknowledged.
- **CPU reads**
  - `CPU_RD` latches `CPU_ADDR` and sets `CPU_WAIT` in the next cycle.
  - `CPU_RD` while `CPU_WAIT`=1 is ignored, and the original address is kept.
- **Timing rules**
  - `MEM_ACK` is ignored in IDLE.
  - IDLE lasts at least one cycle between requests.
  - `DL_ACTIVE` falling has no direct effect; the FIFO simply drains.
- **Reset**
  - Reset mid-request drops `MEM_REQ` at the next edge without waiting for `MEM_ACK`.
  - The memory controller must tolerate an abandoned request. A stray `MEM_ACK` after reset is ignored, because the block is then in IDLE.

## Timing
- Reset values:
  - state IDLE, FIFO count 0.
  - `MEM_REQ`, `MEM_WE`, `DL_WAIT`, `DL_OVF`, `CPU_WAIT` all 0.
  - `MEM_ADDR`, `MEM_DIN`, `CPU_DATA` all 0.
  - `DL_BUSY` = `DL_ACTIVE`.
- Push at cycle N into an empty FIFO while in IDLE gives count 1 at N+1. The block pops at N+1 and shows `MEM_REQ`=1 with `MEM_WE`=1 at N+2.
- An ack at cycle M gives `MEM_REQ`=0 and IDLE at M+1. The next request is at M+2 at the earliest.
- Per-write cost is 2 cycles plus the ack latency.
  - With a 1-cycle ack latency, sustained throughput is one byte every 3 cycles.
  - With `DEPTH`=2, a producer strobing every cycle sees `DL_WAIT` asserted.
- A read strobe at N, with the block IDLE and not busy, gives:
  - `CPU_WAIT`=1 at N+1;
  - `MEM_REQ` at N+2;
  - `CPU_DATA` valid and `CPU_WAIT`=0 in the cycle after `MEM_ACK`.
- `DL_BUSY` falls in the cycle after the final write's ack, provided `DL_ACTIVE`=0.

## Test plan
- **Single write.** With a 1-cycle ack, push {0x00123, 0xA5}. Expect `MEM_REQ` high for 2 cycles with `MEM_WE`=1, `MEM_ADDR`=0x00123 and `MEM_DIN`=0xA5. `DL_BUSY` falls once `DL_ACTIVE` drops.
- **Back-pressure.** With a 5-cycle ack, the producer honours `DL_WAIT` while streaming 16 bytes (addr 0..15, data = addr ^ 0x5A). Expect all 16 writes in order, `DL_WAIT` pulses observed, and `DL_OVF`=0.
- **Overflow.** Force 3 pushes on consecutive cycles against a memory that never acks. Expect the 3rd push dropped, `DL_OVF`=1 and held, and `DL_WAIT`=1.
- **Read blocked by download.** `CPU_RD` at 0x1FFFF during an active download. Expect `CPU_WAIT` held until `DL_BUSY`=0, then one read request. Memory returns 0x3C, so `CPU_DATA`=0x3C and `CPU_WAIT`=0.
- **Ignored second read.** `CPU_RD` twice, at 0x00010 then 0x00020, while `CPU_WAIT`=1. Expect only 0x00010 issued.
- **Reset mid-write.** Assert `RESET` while WR is waiting for its ack, then deliver a stray `MEM_ACK` afterwards. Expect `MEM_REQ`=0 at the next edge, the FIFO empty, and no state change from the stray ack.

Source files
------------

// File: rtl/cart_mem_arb.sv
// Cartridge memory arbiter: buffers ROM-init download bytes in a small FIFO and
// serializes those writes with CPU cartridge reads onto one req/ack memory port.
module cart_mem_arb #(
    parameter int unsigned AW    = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic          CLK_SYS,
    input  logic          RESET,
    input  logic          DL_ACTIVE,
    input  logic [AW-1:0] DL_ADDR,
    input  logic [7:0]    DL_DATA,
    input  logic          DL_VALID,
    output logic          DL_WAIT,
    output logic          DL_OVF,
    output logic          DL_BUSY,
    input  logic          CPU_RD,
    input  logic [AW-1:0] CPU_ADDR,
    output logic [7:0]    CPU_DATA,
    output logic          CPU_WAIT,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [7:0]    MEM_DIN,
    input  logic [7:0]    MEM_DOUT,
    input  logic          MEM_ACK
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] Full = DEPTH[PW:0];

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   fifo_addr_q [DEPTH];
    logic [7:0]      fifo_data_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            dl_active_q;
    logic            cpu_wait_q, cpu_wait_d;
    logic [AW-1:0]   cpu_addr_q, cpu_addr_d;
    logic [7:0]      cpu_data_q, cpu_data_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_din_q, mem_din_d;

    logic fifo_full, fifo_empty, pop, push_ok, drop, rd_done, cpu_accept;

    assign fifo_full  = (count_q == Full);
    assign fifo_empty = (count_q == '0);
    // A pop in the same cycle frees a slot, so a push against a full FIFO is legal then.
    assign push_ok    = DL_VALID && (!fifo_full || pop);
    assign drop       = DL_VALID && fifo_full && !pop;
    assign cpu_accept = CPU_RD && !cpu_wait_q;

    assign DL_WAIT  = fifo_full;
    assign DL_OVF   = ovf_q;
    assign DL_BUSY  = DL_ACTIVE || !fifo_empty || (state_q == StWr);
    assign CPU_DATA = cpu_data_q;
    assign CPU_WAIT = cpu_wait_q;
    assign MEM_REQ  = (state_q != StIdle);
    assign MEM_WE   = mem_we_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DIN  = mem_din_q;

    always_comb begin
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        cpu_data_d = cpu_data_q;
        rd_done    = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_d    = StWr;
                    mem_we_d   = 1'b1;
                    mem_addr_d = fifo_addr_q[rd_ptr_q];
                    mem_din_d  = fifo_data_q[rd_ptr_q];
                end else if (cpu_wait_q && !DL_BUSY) begin
                    state_d    = StRd;
                    mem_we_d   = 1'b0;
                    mem_addr_d = cpu_addr_q;
                end
            end
            StWr: begin
                if (MEM_ACK) state_d = StIdle;
            end
            StRd: begin
                if (MEM_ACK) begin
                    state_d    = StIdle;
                    cpu_data_d = MEM_DOUT;
                    rd_done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        // Sticky overflow clears on a new download session.
        ovf_d      = drop || (ovf_q && !(DL_ACTIVE && !dl_active_q));
        cpu_wait_d = rd_done ? 1'b0 : (cpu_accept ? 1'b1 : cpu_wait_q);
        cpu_addr_d = cpu_accept ? CPU_ADDR : cpu_addr_q;
    end

    always_ff @(posedge CLK_SYS) begin
        if (RESET) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            dl_active_q <= 1'b0;
            cpu_wait_q  <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_data_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            dl_active_q <= DL_ACTIVE;
            cpu_wait_q  <= cpu_wait_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_data_q  <= cpu_data_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (push_ok) begin
            fifo_addr_q[wr_ptr_q] <= DL_ADDR;
            fifo_data_q[wr_ptr_q] <= DL_DATA;
        end
    end

endmodule

// File: tb/tb_cart_mem_arb.sv
// Bench for cart_mem_arb: directed steps plus randomized download/read rounds, checked
// against an ordered write list and a last-write-wins memory model.
module tb_cart_mem_arb;

    logic        clk = 1'b0;
    logic        rst, dl_active, dl_valid, cpu_rd;
    logic [16:0] dl_addr, cpu_addr;
    logic [7:0]  dl_data;
    logic        mem_ack  = 1'b0;
    logic [7:0]  mem_dout = 8'h00;
    logic        dl_wait_o, dl_ovf_o, dl_busy_o, cpu_wait_o, mem_req_o, mem_we_o;
    logic [7:0]  cpu_data_o, mem_din_o;
    logic [16:0] mem_addr_o;

    always #5 clk = ~clk;

    cart_mem_arb #(.AW(17), .DEPTH(2)) dut (
        .CLK_SYS(clk), .RESET(rst), .DL_ACTIVE(dl_active), .DL_ADDR(dl_addr),
        .DL_DATA(dl_data), .DL_VALID(dl_valid), .DL_WAIT(dl_wait_o), .DL_OVF(dl_ovf_o),
        .DL_BUSY(dl_busy_o), .CPU_RD(cpu_rd), .CPU_ADDR(cpu_addr), .CPU_DATA(cpu_data_o),
        .CPU_WAIT(cpu_wait_o), .MEM_REQ(mem_req_o), .MEM_WE(mem_we_o),
        .MEM_ADDR(mem_addr_o), .MEM_DIN(mem_din_o), .MEM_DOUT(mem_dout), .MEM_ACK(mem_ack)
    );

    typedef struct packed {logic [16:0] a; logic [7:0] d;} wr_t;

    int          checks = 0, errors = 0;
    int          lat = 1;
    bit          auto_ack = 1'b1;
    int          wr_done = 0, rd_done = 0, stray_req = 0, stray_done = 0, waits_seen = 0;
    wr_t         wr_exp[$];
    logic [16:0] rd_exp[$];
    logic [7:0]  mem_arr[int];
    logic [7:0]  ref_mem[int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [16:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [16:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    // Memory responder: acks after lat+1 request cycles and checks each transaction.
    logic        in_req = 1'b0, stable = 1'b0, cap_we = 1'b0;
    logic [16:0] cap_a = '0;
    logic [7:0]  cap_d = '0;
    int          cnt = 0;

    always @(posedge clk) begin
        #1;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (stray_req != stray_done) begin
            mem_ack = 1'b1;
            stray_done++;
        end else if (mem_req_o) begin
            if (!in_req) begin
                in_req = 1'b1; cnt = 0; stable = 1'b1;
                cap_we = mem_we_o; cap_a = mem_addr_o; cap_d = mem_din_o;
            end else if (mem_we_o !== cap_we || mem_addr_o !== cap_a ||
                         (cap_we && mem_din_o !== cap_d)) begin
                stable = 1'b0;
            end
            if (auto_ack) cnt++;
            if (auto_ack && cnt > lat) begin
                in_req = 1'b0;
                check("req_stable", stable, 1);
                if (cap_we) begin
                    check("wr_expected", 32'(wr_exp.size() != 0), 1);
                    if (wr_exp.size() != 0) begin
                        check("wr_addr", cap_a, wr_exp[0].a);
                        check("wr_data", cap_d, wr_exp[0].d);
                        void'(wr_exp.pop_front());
                    end
                    mem_arr[int'(cap_a)] = cap_d;
                    wr_done++;
                end else begin
                    check("rd_expected", 32'(rd_exp.size() != 0), 1);
                    if (rd_exp.size() != 0) begin
                        check("rd_addr", cap_a, rd_exp[0]);
                        void'(rd_exp.pop_front());
                    end
                    check("rd_not_during_dl", {wr_exp.size() == 0, dl_active}, 2'b10);
                    mem_dout = mem_arr.exists(int'(cap_a)) ? mem_arr[int'(cap_a)] : dflt(cap_a);
                    rd_done++;
                end
                mem_ack = 1'b1;
            end
        end else begin
            in_req = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [16:0] a, input logic [7:0] d);
        int n = 0;
        while (dl_wait_o === 1'b1 && n < 200) begin
            waits_seen++;
            tick();
            n++;
        end
        if (n >= 200) check("push_wait_bound", 32'(n), 0);
        dl_valid = 1'b1; dl_addr = a; dl_data = d;
        wr_exp.push_back('{a: a, d: d});
        ref_mem[int'(a)] = d;
        tick();
        dl_valid = 1'b0;
    endtask

    task automatic strobe(input logic [16:0] a, input logic [7:0] d, input bit accepted);
        dl_valid = 1'b1; dl_addr = a; dl_data = d;
        if (accepted) begin
            wr_exp.push_back('{a: a, d: d});
            ref_mem[int'(a)] = d;
        end
        tick();
        dl_valid = 1'b0;
    endtask

    task automatic read(input logic [16:0] a);
        cpu_rd = 1'b1; cpu_addr = a;
        if (rd_exp.size() == 0) rd_exp.push_back(a);
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((dl_busy_o !== 1'b0 || cpu_wait_o !== 1'b0 || mem_req_o !== 1'b0) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_quiet_bound"}, 32'(n < 500), 1);
        check({tag, "_writes_drained"}, 32'(wr_exp.size()), 0);
        check({tag, "_reads_drained"}, 32'(rd_exp.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [16:0] ra;
        rst = 1'b1; dl_active = 1'b0; dl_valid = 1'b0; cpu_rd = 1'b0;
        dl_addr = '0; dl_data = '0; cpu_addr = '0;
        repeat (3) tick();

        // Reset values
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_dl_wait", dl_wait_o, 0);
        check("rst_dl_ovf", dl_ovf_o, 0);
        check("rst_cpu_wait", cpu_wait_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_din", mem_din_o, 0);
        check("rst_cpu_data", cpu_data_o, 0);
        check("rst_busy_idle", dl_busy_o, 0);
        dl_active = 1'b1;
        #1 check("rst_busy_active", dl_busy_o, 1);
        dl_active = 1'b0;
        rst = 1'b0;
        tick();

        // Single write, 1-cycle ack
        lat = 1;
        dl_active = 1'b1;
        tick();
        push(17'h00123, 8'hA5);
        check("sw_not_yet", mem_req_o, 0);
        tick();
        check("sw_req1", mem_req_o, 1);
        check("sw_we", mem_we_o, 1);
        check("sw_addr", mem_addr_o, 17'h00123);
        check("sw_din", mem_din_o, 8'hA5);
        tick();
        check("sw_req2", mem_req_o, 1);
        tick();
        check("sw_req_done", mem_req_o, 0);
        check("sw_busy_active", dl_busy_o, 1);
        dl_active = 1'b0;
        #1 check("sw_busy_fall", dl_busy_o, 0);
        check("sw_count", 32'(wr_done), 1);

        // Back-pressure, 5-cycle ack
        lat = 5;
        waits_seen = 0;
        base = wr_done;
        dl_active = 1'b1;
        for (int i = 0; i < 16; i++) push(17'(i), 8'(i) ^ 8'h5A);
        dl_active = 1'b0;
        wait_quiet("bp");
        check("bp_wait_seen", 32'(waits_seen != 0), 1);
        check("bp_writes", 32'(wr_done - base), 16);
        check("bp_no_ovf", dl_ovf_o, 0);

        // Overflow against a memory that never acks
        auto_ack = 1'b0;
        lat = 1;
        dl_active = 1'b1;
        push(17'h00300, 8'h11);
        tick();
        tick();
        check("ovf_stuck_req", mem_req_o, 1);
        strobe(17'h00301, 8'h22, 1'b1);
        strobe(17'h00302, 8'h33, 1'b1);
        strobe(17'h00303, 8'h44, 1'b0);
        check("ovf_set", dl_ovf_o, 1);
        check("ovf_wait", dl_wait_o, 1);
        repeat (3) tick();
        check("ovf_held", dl_ovf_o, 1);
        auto_ack = 1'b1;
        dl_active = 1'b0;
        wait_quiet("ovf");
        check("ovf_sticky_after_fall", dl_ovf_o, 1);
        dl_active = 1'b1;
        tick();
        check("ovf_cleared_on_rise", dl_ovf_o, 0);
        dl_active = 1'b0;
        tick();

        // Read blocked by an active download
        lat = 2;
        base = rd_done;
        dl_active = 1'b1;
        push(17'h1FFF0, 8'h12);
        push(17'h1FFF1, 8'h34);
        read(17'h1FFFF);
        repeat (10) tick();
        check("rb_wait_held", cpu_wait_o, 1);
        check("rb_no_read_yet", 32'(rd_done - base), 0);
        dl_active = 1'b0;
        wait_quiet("rb");
        check("rb_data", cpu_data_o, 8'h3C);
        check("rb_wait_clear", cpu_wait_o, 0);
        check("rb_one_read", 32'(rd_done - base), 1);

        // Second read while pending is ignored
        base = rd_done;
        cpu_rd = 1'b1; cpu_addr = 17'h00010;
        rd_exp.push_back(17'h00010);
        tick();
        check("ir_wait", cpu_wait_o, 1);
        check("ir_no_req_yet", mem_req_o, 0);
        cpu_addr = 17'h00020;
        tick();
        cpu_rd = 1'b0;
        check("ir_req", mem_req_o, 1);
        check("ir_we", mem_we_o, 0);
        check("ir_addr", mem_addr_o, 17'h00010);
        wait_quiet("ir");
        check("ir_data", cpu_data_o, ref_rd(17'h00010));
        check("ir_one_read", 32'(rd_done - base), 1);

        // Randomized download rounds followed by a read-back
        for (int r = 0; r < 20; r++) begin
            lat = $urandom_range(1, 4);
            ra = 17'($urandom_range(0, 63));
            dl_active = 1'b1;
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                push(17'($urandom_range(0, 63)), 8'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            if ($urandom_range(0, 1) == 1) read(ra);
            repeat ($urandom_range(0, 3)) tick();
            dl_active = 1'b0;
            wait_quiet("rnd_dl");
            if (rd_exp.size() == 0 && cpu_data_o !== ref_rd(ra)) read(ra);
            wait_quiet("rnd_rd");
            check("rnd_data", cpu_data_o, ref_rd(ra));
        end

        // Reset while a write waits for its ack, then a stray ack
        auto_ack = 1'b0;
        dl_active = 1'b1;
        push(17'h0AAAA, 8'h77);
        tick();
        check("rw_req", mem_req_o, 1);
        rst = 1'b1;
        tick();
        check("rw_req_dropped", mem_req_o, 0);
        rst = 1'b0;
        dl_active = 1'b0;
        wr_exp.delete();
        ref_mem.delete(int'(17'h0AAAA));
        #1 check("rw_fifo_empty", {dl_busy_o, dl_wait_o}, 2'b00);
        stray_req++;
        repeat (3) tick();
        check("rw_stray_req", mem_req_o, 0);
        check("rw_stray_busy", dl_busy_o, 0);
        check("rw_stray_cpu_wait", cpu_wait_o, 0);
        check("rw_cpu_data", cpu_data_o, 0);
        auto_ack = 1'b1;
        lat = 1;
        read(17'h00005);
        wait_quiet("rw_after");
        check("rw_after_data", cpu_data_o, ref_rd(17'h00005));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
